pc_fetch_unit: RTL and testbench

Instruction-fetch front end of the single-issue CPU. It owns the program counter, issues one instruction-memory request at a time, and holds the fetched instruction for decode under a valid/ready handshake. Its `seq_pc` output drives the `i0` leg of the next-PC 2:1 mux. That mux's output and select return to this block as `redirect_pc` and `redirect`.

---
 rtl/pc_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Purpose : instruction-fetch front end; owns the PC, issues one imem request at a time,
//           holds the fetched word for decode under valid/ready.
// Latency : request-to-if_valid 2 cycles best case (grant in REQ, rvalid next cycle); 1 instr / 3 cycles.
// Backpressure: imem_gnt, imem_rvalid and if_ready may stall indefinitely; all outputs hold meanwhile.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   redirect, redirect_pc     next-PC mux select / mux output (taken branch or jump)
//   imem_req, imem_addr       request valid and word-aligned address (registered)
//   imem_gnt                  request accepted this cycle
//   imem_rvalid, imem_rdata   read response
//   if_valid, if_ready        decode handshake
//   if_instr, if_pc           fetched instruction and its address
//   seq_pc                    if_pc + PC_STEP, feeds the next-PC mux i0 leg
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] seq_pc
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:2] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    // Byte-offset bits of the redirect target are architecturally dropped.
    logic        unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        unique case (state_q)
            ST_START: begin
                state_d = ST_REQ;
                if (redirect) begin
                    pc_d = redirect_pc[31:2];
                end
            end

            ST_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc[31:2];
                end
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                    // A redirect in the grant cycle means the request already went out
                    // with the stale address; its response must be dropped.
                    kill_d  = redirect;
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    kill_d = 1'b0;
                    if (redirect) begin
                        // Response belongs to the old path; drop it and refetch the target.
                        pc_d    = redirect_pc[31:2];
                        state_d = ST_REQ;
                    end else if (kill_q) begin
                        state_d = ST_REQ;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = {pc_q, 2'b00};
                        pc_d       = pc_q + PC_STEP[31:2];
                        state_d    = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Cannot cancel the outstanding request; mark it for discard instead.
                    pc_d   = redirect_pc[31:2];
                    kill_d = 1'b1;
                end
            end

            ST_HOLD: begin
                // A redirect abandons the held word; a same-cycle if_ready still
                // counts as a transfer on the decode side.
                if (redirect) begin
                    pc_d    = redirect_pc[31:2];
                    state_d = ST_REQ;
                end else if (if_ready) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_START;
            pc_q       <= RESET_PC[31:2];
            kill_q     <= 1'b0;
            if_instr_q <= 32'h0000_0000;
            if_pc_q    <= {RESET_PC[31:2], 2'b00};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    // Everything except seq_pc is decoded straight from flops.
    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = {pc_q, 2'b00};
    assign if_valid  = (state_q == ST_HOLD);
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign seq_pc    = if_pc_q + PC_STEP;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 0: RESET_PC = 0x100 ----------------
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_instr, if_pc, seq_pc;

    pc_fetch_unit #(.RESET_PC(32'h0000_0100), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .seq_pc(seq_pc)
    );

    // ---------------- DUT 1: RESET_PC = 0xFFFF_FFFC (wrap) ----------------
    logic        imem_req1;
    logic [31:0] imem_addr1;
    logic        imem_gnt1 = 1'b0;
    logic        imem_rvalid1 = 1'b0;
    logic [31:0] imem_rdata1 = 32'h0;
    logic        if_valid1;
    logic [31:0] if_instr1, if_pc1, seq_pc1;

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
        .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req(imem_req1), .imem_addr(imem_addr1), .imem_gnt(imem_gnt1),
        .imem_rvalid(imem_rvalid1), .imem_rdata(imem_rdata1),
        .if_valid(if_valid1), .if_ready(1'b1), .if_instr(if_instr1),
        .if_pc(if_pc1), .seq_pc(seq_pc1)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = instr_of(pc);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int max, input string nm);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check({"drain ", nm}, exp_q.size(), 0);
    endtask

    // ---------------- memory model for DUT 0 ----------------
    // Inputs change at negedge+1 so that stimulus settings changed at negedge are seen.
    logic        gnt_en = 1'b0;
    int          rsp_delay = 1;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [31:0] paddr = 32'h0;

    always begin
        @(negedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_BAD0;
        if (pend) begin
            if (pcnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(paddr);
                pend        = 1'b0;
            end else begin
                pcnt--;
            end
        end
        imem_gnt = imem_req & gnt_en;
        if (imem_gnt) begin
            pend  = 1'b1;
            pcnt  = rsp_delay;
            paddr = imem_addr;
        end
    end

    // ---------------- memory model for DUT 1: always grant, 1-cycle rvalid ----------------
    logic        pend1 = 1'b0;
    logic [31:0] paddr1 = 32'h0;

    always begin
        @(negedge clk);
        #1;
        imem_rvalid1 = 1'b0;
        if (pend1) begin
            imem_rvalid1 = 1'b1;
            imem_rdata1  = instr_of(paddr1);
            pend1        = 1'b0;
        end
        imem_gnt1 = imem_req1;
        if (imem_req1) begin
            pend1  = 1'b1;
            paddr1 = imem_addr1;
        end
    end

    // ---------------- scoreboard monitor for DUT 0 ----------------
    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (if_valid === 1'b1 && if_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_xfer: got pc %h instr %h, expected no transfer", if_pc, if_instr);
            end else begin
                e = exp_q.pop_front();
                check("xfer if_pc", if_pc, e.pc);
                check("xfer if_instr", if_instr, e.instr);
                check("xfer seq_pc", seq_pc, e.pc + 32'd4);
                xfer_q.push_back(cyc);
            end
        end
    end

    // ---------------- wrap-around checks on DUT 1 ----------------
    logic done1 = 1'b0;

    initial begin : wrap_chk
        int seen;
        seen = 0;
        wait (rst === 1'b1);
        wait (rst === 1'b0);
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk);
            #2;
            if (if_valid1 === 1'b1) begin
                if (seen == 0) begin
                    check("wrap first if_pc", if_pc1, 32'hFFFF_FFFC);
                    check("wrap first seq_pc", seq_pc1, 32'h0000_0000);
                    check("wrap first if_instr", if_instr1, instr_of(32'hFFFF_FFFC));
                end else begin
                    check("wrap second if_pc", if_pc1, 32'h0000_0000);
                    check("wrap second if_instr", if_instr1, instr_of(32'h0000_0000));
                end
                seen++;
            end
        end
        check("wrap fetch count", seen, 2);
        done1 = 1'b1;
    end

    // ---------------- directed stimulus ----------------
    initial begin : main
        int req_cyc;

        // Reset values
        rst = 1'b1; if_ready = 1'b1; gnt_en = 1'b1; rsp_delay = 1;
        repeat (2) @(negedge clk);
        #3;
        check("rst imem_req", imem_req, 0);
        check("rst imem_addr", imem_addr, 32'h100);
        check("rst if_valid", if_valid, 0);
        check("rst if_pc", if_pc, 32'h100);
        check("rst if_instr", if_instr, 32'h0);
        check("rst seq_pc", seq_pc, 32'h104);

        // Streaming: 0x100, 0x104, 0x108 with always-grant, 1-cycle rvalid
        @(negedge clk);
        rst = 1'b0;
        push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
        #3;
        check("start imem_req", imem_req, 0);
        @(negedge clk);
        #3;
        check("first imem_req", imem_req, 1);
        check("first imem_addr", imem_addr, 32'h100);
        req_cyc = cyc;
        wait_drain(30, "stream");
        if (xfer_q.size() >= 3) begin
            check("req->valid latency", xfer_q[0] - req_cyc, 2);
            check("valid spacing 1", xfer_q[1] - xfer_q[0], 3);
            check("valid spacing 2", xfer_q[2] - xfer_q[1], 3);
        end else begin
            check("stream xfer count", xfer_q.size(), 3);
        end

        // Decode backpressure: fetch 0x10C then hold if_ready low for 5 cycles
        if_ready = 1'b0;
        push_exp(32'h10C);
        @(negedge clk);
        gnt_en = 1'b0;
        #3;
        for (int i = 0; i < 20 && if_valid !== 1'b1; i++) begin
            @(negedge clk);
            #3;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #3;
            end
            check("stall if_valid", if_valid, 1);
            check("stall if_pc", if_pc, 32'h10C);
            check("stall if_instr", if_instr, instr_of(32'h10C));
            check("stall imem_req", imem_req, 0);
        end
        @(negedge clk);
        if_ready = 1'b1;
        @(negedge clk);
        #3;
        check("post-stall imem_req", imem_req, 1);
        check("post-stall imem_addr", imem_addr, 32'h110);

        // Grant withheld 4 cycles; redirect to 0x2003 on cycle 2
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h2003;
        #3;
        check("redir-req addr same cycle", imem_addr, 32'h110);
        @(negedge clk);
        redirect = 1'b0;
        #3;
        check("redir-req addr c3", imem_addr, 32'h2000);
        @(negedge clk);
        #3;
        check("redir-req addr c4", imem_addr, 32'h2000);
        check("redir-req imem_req c4", imem_req, 1);
        @(negedge clk);
        push_exp(32'h2000);
        gnt_en = 1'b1;
        wait_drain(20, "redir-req");

        // Redirect to 0x400 while WAIT; old response returns 2 cycles later
        rsp_delay = 3;
        push_exp(32'h400);
        @(negedge clk);
        rsp_delay = 1;
        redirect = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        redirect = 1'b0;
        #3;
        check("redir-wait imem_req", imem_req, 0);
        @(negedge clk);
        @(negedge clk);
        #3;
        check("redir-wait next req", imem_req, 1);
        check("redir-wait next addr", imem_addr, 32'h400);
        check("redir-wait if_valid", if_valid, 0);
        wait_drain(20, "redir-wait");

        // Redirect to 0x800 in the same cycle as rvalid
        rsp_delay = 2;
        push_exp(32'h800);
        @(negedge clk);
        rsp_delay = 1;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h800;
        @(negedge clk);
        redirect = 1'b0;
        #3;
        check("redir-rvalid next req", imem_req, 1);
        check("redir-rvalid next addr", imem_addr, 32'h800);
        check("redir-rvalid if_valid", if_valid, 0);
        wait_drain(20, "redir-rvalid");

        // Reset while WAIT; stale rvalid arrives the cycle after reset
        rsp_delay = 2;
        push_exp(32'h100);
        @(negedge clk);
        rst = 1'b1;
        rsp_delay = 1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("rst-wait if_valid c0", if_valid, 0);
        check("rst-wait imem_req c0", imem_req, 0);
        check("rst-wait if_pc", if_pc, 32'h100);
        check("rst-wait if_instr", if_instr, 32'h0);
        @(negedge clk);
        #3;
        check("rst-wait imem_req c1", imem_req, 1);
        check("rst-wait imem_addr c1", imem_addr, 32'h100);
        check("rst-wait if_valid c1", if_valid, 0);
        @(negedge clk);
        #3;
        check("rst-wait if_valid c2", if_valid, 0);
        wait_drain(20, "rst-wait");

        for (int i = 0; i < 100 && done1 !== 1'b1; i++) @(negedge clk);
        check("wrap checker done", done1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
